// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// The datapath side is the master: it supplies hazard sources and consumes enables/flushes.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        ExMemRead;
  logic [4:0]  ExRt;
  logic        MemBranch;
  logic        MemZero;
  logic        MemAccess;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXWrite;
  logic        EXMEMWrite;
  logic        MEMWBWrite;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        EXMEMFlush;
  logic        PCSrc;
  logic [1:0]  State;
  logic [15:0] StallCount;

  modport master (
    output IdRs, IdRt, ExMemRead, ExRt, MemBranch, MemZero, MemAccess,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
    input  IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc, State, StallCount
  );

  modport slave (
    input  IdRs, IdRt, ExMemRead, ExRt, MemBranch, MemZero, MemAccess,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
    output IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc, State, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, taken-branch flushes in MEM,
// and whole-pipeline freeze while a multi-cycle data-memory access completes.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_WAIT    = 2'b01;
  localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [15:0] r_stall_count;

  logic w_mem_stall;
  logic w_taken;
  logic w_load_use;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_exmem_write;
  logic w_memwb_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_exmem_flush;
  logic w_pc_src;

  // In WAIT, MemAccess still belongs to the access being serviced, so only RUN may start a wait.
  assign w_mem_stall = ((r_state == S_RUN) && bus.MemAccess && HAS_WAIT) ||
                       ((r_state == S_WAIT) && (r_cnt != 4'd0));
  assign w_taken     = bus.MemBranch & bus.MemZero;
  assign w_load_use  = bus.ExMemRead && (bus.ExRt != 5'd0) &&
                       ((bus.ExRt == bus.IdRs) || (bus.ExRt == bus.IdRt));

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_exmem_write = 1'b1;
    w_memwb_write = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_pc_src      = 1'b0;
    w_state_next  = S_RUN;
    w_cnt_next    = 4'd0;

    if (Rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_write  = 1'b0;
      w_exmem_write = 1'b0;
      w_memwb_write = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_mem_stall) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_write  = 1'b0;
      w_exmem_write = 1'b0;
      w_memwb_write = 1'b0;
      w_state_next  = S_WAIT;
      w_cnt_next    = (r_state == S_RUN) ? WAIT_LOAD : (r_cnt - 4'd1);
    end else if (w_taken) begin
      // Younger instructions are discarded, so a coincident load-use needs no bubble.
      w_pc_src      = 1'b1;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_RUN;
      r_cnt         <= 4'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!w_pc_write && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign bus.PCWrite    = w_pc_write;
  assign bus.IFIDWrite  = w_ifid_write;
  assign bus.IDEXWrite  = w_idex_write;
  assign bus.EXMEMWrite = w_exmem_write;
  assign bus.MEMWBWrite = w_memwb_write;
  assign bus.IFIDFlush  = w_ifid_flush;
  assign bus.IDEXFlush  = w_idex_flush;
  assign bus.EXMEMFlush = w_exmem_flush;
  assign bus.PCSrc      = w_pc_src;
  assign bus.State      = r_state;
  assign bus.StallCount = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: four instances (MEM_WAIT = 2, 0, 3, 5)
// driven one at a time; each cycle's expected outputs are queued and checked at negedge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [4];
  logic [4:0] idrs_v  [4];
  logic [4:0] idrt_v  [4];
  logic       exmr_v  [4];
  logic [4:0] exrt_v  [4];
  logic       mb_v    [4];
  logic       mz_v    [4];
  logic       ma_v    [4];
  logic [26:0] obs    [4];

  pipeline_hazard_ctrl_if bus_if [4] ();

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int MW = (gi == 0) ? 2 : (gi == 1) ? 0 : (gi == 2) ? 3 : 5;
    pipeline_hazard_ctrl #(.MEM_WAIT(MW)) u_dut (
      .Clk (clk),
      .Rst (rst_v[gi]),
      .bus (bus_if[gi])
    );
    assign bus_if[gi].IdRs      = idrs_v[gi];
    assign bus_if[gi].IdRt      = idrt_v[gi];
    assign bus_if[gi].ExMemRead = exmr_v[gi];
    assign bus_if[gi].ExRt      = exrt_v[gi];
    assign bus_if[gi].MemBranch = mb_v[gi];
    assign bus_if[gi].MemZero   = mz_v[gi];
    assign bus_if[gi].MemAccess = ma_v[gi];
    // {PC,IFID,IDEX,EXMEM,MEMWB writes, IFID,IDEX,EXMEM flushes, PCSrc, State, StallCount}
    assign obs[gi] = {bus_if[gi].PCWrite, bus_if[gi].IFIDWrite, bus_if[gi].IDEXWrite,
                      bus_if[gi].EXMEMWrite, bus_if[gi].MEMWBWrite,
                      bus_if[gi].IFIDFlush, bus_if[gi].IDEXFlush, bus_if[gi].EXMEMFlush,
                      bus_if[gi].PCSrc, bus_if[gi].State, bus_if[gi].StallCount};
  end

  typedef struct {
    string       tag;
    int          d;
    logic [4:0]  wr;
    logic [2:0]  fl;
    logic        pc;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t sb_q [$];
  exp_t cur;
  int   exp_sc [4];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      check_value({cur.tag, ".wr"}, 32'(obs[cur.d][26:22]), 32'(cur.wr));
      check_value({cur.tag, ".fl"}, 32'(obs[cur.d][21:19]), 32'(cur.fl));
      check_value({cur.tag, ".pcsrc"}, 32'(obs[cur.d][18]), 32'(cur.pc));
      check_value({cur.tag, ".state"}, 32'(obs[cur.d][17:16]), 32'(cur.st));
      check_value({cur.tag, ".stalls"}, 32'(obs[cur.d][15:0]), 32'(cur.sc));
      $display("txn %-12s dut%0d wr=%b fl=%b pcsrc=%b state=%0d stalls=%0d",
               cur.tag, cur.d, obs[cur.d][26:22], obs[cur.d][21:19], obs[cur.d][18],
               obs[cur.d][17:16], obs[cur.d][15:0]);
    end
  end

  // One cycle: drive dut d just after the edge, queue what it must show before the next edge.
  task automatic step(input string tag, input int d, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic exmr, input logic [4:0] exrt,
                      input logic mb, input logic mz, input logic ma,
                      input logic [4:0] ewr, input logic [2:0] efl,
                      input logic epc, input logic [1:0] est);
    exp_t e;
    @(posedge clk);
    #1;
    rst_v[d]  = r;
    idrs_v[d] = rs;
    idrt_v[d] = rt;
    exmr_v[d] = exmr;
    exrt_v[d] = exrt;
    mb_v[d]   = mb;
    mz_v[d]   = mz;
    ma_v[d]   = ma;
    e.tag = tag; e.d = d; e.wr = ewr; e.fl = efl; e.pc = epc; e.st = est;
    e.sc  = 16'(exp_sc[d]);
    sb_q.push_back(e);
    if (r) exp_sc[d] = 0;
    else if (!ewr[4] && exp_sc[d] < 65535) exp_sc[d] = exp_sc[d] + 1;
  endtask

  localparam logic [4:0] W_ALL  = 5'b11111;
  localparam logic [4:0] W_NONE = 5'b00000;
  localparam logic [4:0] W_LU   = 5'b00111;
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_ALL  = 3'b111;
  localparam logic [2:0] F_IDEX = 3'b010;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; idrs_v[i] = '0; idrt_v[i] = '0; exmr_v[i] = 1'b0;
      exrt_v[i] = '0; mb_v[i] = 1'b0; mz_v[i] = 1'b0; ma_v[i] = 1'b0; exp_sc[i] = 0;
    end
    @(posedge clk);

    // MEM_WAIT = 2 instance: reset, load-use, memory waits, branches
    step("rst",        0, 1, 0, 0, 0, 0, 0, 0, 0, W_NONE, F_ALL,  0, 0);
    for (int i = 1; i < 4; i++) rst_v[i] = 1'b0;
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("lu_rs",      0, 0, 5, 0, 1, 5, 0, 0, 0, W_LU,   F_IDEX, 0, 0);
    step("lu_after",   0, 0, 5, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("lu_rt",      0, 0, 3, 7, 1, 7, 0, 0, 0, W_LU,   F_IDEX, 0, 0);
    step("lu_r0",      0, 0, 0, 0, 1, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("lu_miss",    0, 0, 6, 7, 1, 5, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("lu_noread",  0, 0, 5, 5, 0, 5, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("mw_c1",      0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("mw_c2",      0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 1);
    step("mw_rel",     0, 0, 0, 0, 0, 0, 0, 0, 1, W_ALL,  F_NONE, 0, 1);
    step("mw_run",     0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("b2b_a1",     0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("b2b_a2",     0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 1);
    step("b2b_arel",   0, 0, 0, 0, 0, 0, 0, 0, 1, W_ALL,  F_NONE, 0, 1);
    step("b2b_b1",     0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("b2b_b2",     0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 1);
    step("b2b_brel",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 1);
    step("b2b_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("mwlu_c1",    0, 0, 9, 0, 1, 9, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("mwlu_c2",    0, 0, 9, 0, 1, 9, 0, 0, 1, W_NONE, F_NONE, 0, 1);
    step("mwlu_rel",   0, 0, 9, 0, 1, 9, 0, 0, 1, W_LU,   F_IDEX, 0, 1);
    step("mwlu_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("br_over_lu", 0, 0, 5, 0, 1, 5, 1, 1, 0, W_ALL,  F_ALL,  1, 0);
    step("br_nt_lu",   0, 0, 5, 0, 1, 5, 1, 0, 0, W_LU,   F_IDEX, 0, 0);
    step("br_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("br_taken",   0, 0, 0, 0, 0, 0, 1, 1, 0, W_ALL,  F_ALL,  1, 0);

    // MEM_WAIT = 0 instance: MemAccess never stalls
    step("mw0_acc",    1, 0, 0, 0, 0, 0, 0, 0, 1, W_ALL,  F_NONE, 0, 0);
    step("mw0_br",     1, 0, 0, 0, 0, 0, 1, 1, 1, W_ALL,  F_ALL,  1, 0);
    step("mw0_lu",     1, 0, 4, 0, 1, 4, 0, 0, 1, W_LU,   F_IDEX, 0, 0);
    step("mw0_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);

    // MEM_WAIT = 3 instance: taken branch held across a wait
    step("bw_c1",      2, 0, 0, 0, 0, 0, 1, 1, 1, W_NONE, F_NONE, 0, 0);
    step("bw_c2",      2, 0, 0, 0, 0, 0, 1, 1, 1, W_NONE, F_NONE, 0, 1);
    step("bw_c3",      2, 0, 0, 0, 0, 0, 1, 1, 1, W_NONE, F_NONE, 0, 1);
    step("bw_rel",     2, 0, 0, 0, 0, 0, 1, 1, 1, W_ALL,  F_ALL,  1, 1);
    step("bw_idle",    2, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);

    // MEM_WAIT = 5 instance: reset during the wait abandons the access
    step("rw_c1",      3, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("rw_rst",     3, 1, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_ALL,  0, 1);
    step("rw_after",   3, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0);
    step("rw_new1",    3, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE, F_NONE, 0, 0);
    step("rw_new2",    3, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE, F_NONE, 0, 1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check_value("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
